// File: rtl/axis_fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// axis_fifo_reader_pkg
//   Shared definitions for the FIFO-to-AXI-Stream reader:
//     occ_e          - occupancy of the two-entry output buffer
//     DATA_WIDTH_DEF - default tdata width
//     TLAST_BIT      - tlast position in the FIFO word at the default width.
//                      tlast always sits directly above tdata, so for other
//                      widths the position shifts by the width difference.
// -----------------------------------------------------------------------------
package axis_fifo_reader_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int TLAST_BIT      = DATA_WIDTH_DEF;

endpackage

// File: rtl/axis_skid_buf.sv
// -----------------------------------------------------------------------------
// axis_skid_buf
//   Two-entry valid/ready buffer. The main register drives the outputs; the
//   skid register catches the one word accepted while the consumer stalls.
//   Upstream ready is a pure function of the occupancy register, so it never
//   depends combinationally on m_ready.
//
// Ports
//   clk_i      in   clock
//   s_rst_n_i  in   synchronous active-low reset
//   s_valid    in   upstream word available
//   s_ready    out  buffer can accept (occupancy EMPTY or ONE)
//   s_data     in   upstream payload [W-1:0]
//   m_valid    out  registered output valid (occupancy ONE or TWO)
//   m_ready    in   downstream ready
//   m_data     out  registered output payload [W-1:0]
// -----------------------------------------------------------------------------
module axis_skid_buf
    import axis_fifo_reader_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         s_rst_n_i,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    occ_e         state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         vld_q;
    logic         push;

    assign s_ready = (state != TWO);
    assign push    = s_valid & s_ready;

    // Occupancy FSM. vld_q is kept as its own flop (rather than decoded from
    // state) so the output valid comes straight from a register.
    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= s_data;
                        vld_q  <= 1'b1;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && m_ready) begin
                        // Word leaves and the next one takes its place:
                        // one word per clock sustained.
                        main_q <= s_data;
                    end else if (push) begin
                        // Consumer stalled; main must stay put, park the
                        // new word in the skid slot.
                        skid_q <= s_data;
                        state  <= TWO;
                    end else if (m_ready) begin
                        vld_q <= 1'b0;
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (m_ready) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                    state <= EMPTY;
                end
            endcase
        end
    end

    assign m_valid = vld_q;
    assign m_data  = main_q;

endmodule

// File: rtl/axis_fifo_reader.sv
// -----------------------------------------------------------------------------
// axis_fifo_reader
//   Drains a first-word-fall-through FIFO onto an AXI-Stream master port
//   through a two-entry skid buffer, and optionally counts completed packets.
//
// Ports
//   clk_i            in   clock
//   s_rst_n_i        in   synchronous active-low reset
//   fifo_data_i      in   FIFO head {tlast, tdata} [DATA_WIDTH:0]
//   fifo_empty_i     in   FIFO empty; head valid when low
//   fifo_rd_en_o     out  FIFO pop (combinational)
//   m_axis_tdata_o   out  stream data [DATA_WIDTH-1:0]
//   m_axis_tlast_o   out  end of packet
//   m_axis_tvalid_o  out  stream valid (registered)
//   m_axis_tready_i  in   downstream ready
//   pkt_cnt_o        out  completed packet count [CNT_WIDTH-1:0]
//
// Build option
//   PKT_CNT_EN  - when defined, pkt_cnt_o counts tlast handshakes (wrapping);
//                 otherwise no counter is built and pkt_cnt_o is 0.
// -----------------------------------------------------------------------------
module axis_fifo_reader
    import axis_fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  s_rst_n_i,
    input  logic [DATA_WIDTH:0]   fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tlast_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_o
);

    localparam int PW        = DATA_WIDTH + 1;
    localparam int TLAST_POS = TLAST_BIT - DATA_WIDTH_DEF + DATA_WIDTH;

    logic          head_vld;
    logic          buf_rdy;
    logic [PW-1:0] buf_out;

    // Reset gates the pop so nothing leaves the FIFO while the buffer is
    // being cleared; the word at the head is the first one sent afterwards.
    assign head_vld     = ~fifo_empty_i & s_rst_n_i;
    assign fifo_rd_en_o = head_vld & buf_rdy;

    axis_skid_buf #(
        .W (PW)
    ) u_buf (
        .clk_i     (clk_i),
        .s_rst_n_i (s_rst_n_i),
        .s_valid   (head_vld),
        .s_ready   (buf_rdy),
        .s_data    (fifo_data_i),
        .m_valid   (m_axis_tvalid_o),
        .m_ready   (m_axis_tready_i),
        .m_data    (buf_out)
    );

    assign m_axis_tdata_o = buf_out[DATA_WIDTH-1:0];
    assign m_axis_tlast_o = buf_out[TLAST_POS];

`ifdef PKT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            cnt_q <= '0;
        end else if (m_axis_tvalid_o && m_axis_tready_i && m_axis_tlast_o) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign pkt_cnt_o = cnt_q;
`else
    assign pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axis_fifo_reader.sv
module tb_axis_fifo_reader;

    localparam int DW    = 16;
    localparam int CNT_W = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW:0]   fifo_data;
    logic          fifo_empty;
    logic          rd_en;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic [CNT_W-1:0] pkt_cnt;

    axis_fifo_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .clk_i           (clk),
        .s_rst_n_i       (rst_n),
        .fifo_data_i     (fifo_data),
        .fifo_empty_i    (fifo_empty),
        .fifo_rd_en_o    (rd_en),
        .m_axis_tdata_o  (tdata),
        .m_axis_tlast_o  (tlast),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tready_i (tready),
        .pkt_cnt_o       (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Source FIFO contents and the expected output stream (same order).
    logic [DW:0] src_q[$];
    logic [DW:0] exp_q[$];
    logic        gap;

    // Reference model state: words held inside the reader, packets seen.
    int n_vec = 0;
    int n_err = 0;
    int occ = 0;
    int cnt_model = 0;
    int rst_edges = 0;
    bit saw_two = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef PKT_CNT_EN
        return CNT_W'(cnt_model);
`else
        return '0;
`endif
    endfunction

    task automatic drive_fifo();
        fifo_empty = gap || (src_q.size() == 0);
        fifo_data  = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic load(input logic [DW-1:0] d, input logic l);
        src_q.push_back({l, d});
        exp_q.push_back({l, d});
        drive_fifo();
    endtask

    // One clock: note whether the FIFO is popped at the coming edge, then
    // apply the next cycle's inputs just after that edge.
    task automatic step(input bit g, input bit rdy);
        bit popped;
        @(negedge clk); #1;
        popped = rd_en;
        @(posedge clk); #1;
        if (popped && src_q.size() != 0) void'(src_q.pop_front());
        gap    = g;
        tready = rdy;
        drive_fifo();
    endtask

    task automatic drain(input string name, input int budget, input bit rnd);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || occ != 0) && n < budget) begin
            if (rnd) step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
            else     step(1'b0, 1'b1);
            n++;
        end
        chk({name, " drained"}, exp_q.size() + src_q.size() + occ, 0);
    endtask

    // Monitor / scoreboard at mid-cycle.
    initial begin
        logic        hs;
        logic        prev_stall;
        logic [DW:0] prev_word;
        logic [DW:0] w;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst rd_en", rd_en, 0);
                if (rst_edges > 0) begin
                    chk("rst tvalid", tvalid, 0);
                    chk("rst tdata", tdata, 0);
                    chk("rst tlast", tlast, 0);
                    chk("rst pkt_cnt", pkt_cnt, 0);
                end else begin
                    // Words buffered in the reader are lost at this edge.
                    repeat (occ) if (exp_q.size() != 0) void'(exp_q.pop_front());
                    occ       = 0;
                    cnt_model = 0;
                end
                rst_edges++;
                prev_stall = 1'b0;
            end else begin
                rst_edges = 0;
                hs = tvalid && tready;
                chk("tvalid", tvalid, (occ != 0));
                chk("rd_en", rd_en, (!fifo_empty && occ < 2));
                if (occ == 2 && !fifo_empty) saw_two = 1;
                if (prev_stall) begin
                    chk("stall tvalid", tvalid, 1);
                    chk("stall word", {tlast, tdata}, prev_word);
                end
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected beat", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        chk("tdata", tdata, w[DW-1:0]);
                        chk("tlast", tlast, w[DW]);
                    end
                end
                chk("pkt_cnt", pkt_cnt, exp_cnt());
                if (hs && tlast) cnt_model++;
                occ = occ + int'(rd_en) - int'(hs);
                prev_stall = tvalid && !tready;
                prev_word  = {tlast, tdata};
            end
        end
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        tready = 1'b0;
        gap    = 1'b0;
        drive_fifo();
        repeat (3) step(1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b1);

        // Three-word packet, consumer always ready.
        load(16'h0011, 1'b0);
        load(16'h0022, 1'b0);
        load(16'h0033, 1'b1);
        drain("basic", 20, 1'b0);
`ifdef PKT_CNT_EN
        chk("basic pkt_cnt", pkt_cnt, 1);
`else
        chk("basic pkt_cnt", pkt_cnt, 0);
`endif

        // Eight words with a stall in the middle of the stream.
        for (int i = 0; i < 8; i++) load(16'h0100 + 16'(i), (i == 7));
        for (int c = 0; c < 6; c++) step(1'b0, !(c >= 3 && c <= 5));
        drain("stall", 40, 1'b0);
        chk("reached TWO", saw_two, 1);

        // Empty toggling every cycle.
        for (int i = 0; i < 8; i++) load(16'h0200 + 16'(i), (i == 7));
        for (int c = 0; c < 30; c++) step((c % 2) == 1, 1'b1);
        drain("toggle", 40, 1'b0);

        // Reset while two words are buffered; the FIFO head survives.
        load(16'h00AA, 1'b0);
        load(16'h00BB, 1'b1);
        load(16'h00CC, 1'b1);
        n = 0;
        while (occ != 2 && n < 10) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("buffer full before reset", occ, 2);
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        drain("reset", 20, 1'b0);

        // Counter wrap: clear, then 17 single-word packets.
        rst_n = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) load(16'h0300 + 16'(i), 1'b1);
        drain("wrap", 60, 1'b0);
`ifdef PKT_CNT_EN
        chk("wrap pkt_cnt", pkt_cnt, 1);
`else
        chk("wrap pkt_cnt", pkt_cnt, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 10000; i++)
            load(16'($urandom), ($urandom_range(0, 7) == 0));
        drain("random", 60000, 1'b1);

        repeat (3) step(1'b0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_fifo_reader.md
AXIS_FIFO_READER -- requirements
Module: axis_fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXI-Stream tdata width in bits.
REQ-002 Parameter CNT_WIDTH, default 32: packet counter width in bits.
REQ-003 clk_i  input  1: single clock for all logic.
REQ-004 s_rst_n_i  input  1: reset, synchronous and active-low, sampled on rising clk_i.
REQ-005 fifo_data_i  input  DATA_WIDTH+1: first-word-fall-through FIFO head; bit DATA_WIDTH = tlast, bits DATA_WIDTH-1:0 = tdata.
REQ-006 fifo_empty_i  input  1: FIFO empty flag; head is valid when low.
REQ-007 fifo_rd_en_o  output  1: FIFO pop; the head is consumed on a rising edge with this signal high.
REQ-008 m_axis_tdata_o  output  DATA_WIDTH: stream data.
REQ-009 m_axis_tlast_o  output  1: end of packet.
REQ-010 m_axis_tvalid_o  output  1: stream valid.
REQ-011 m_axis_tready_i  input  1: downstream ready.
REQ-012 pkt_cnt_o  output  CNT_WIDTH: count of completed packets.

Function
REQ-013 The block SHALL hold a two-entry buffer (main register driving the outputs, skid register) with occupancy states EMPTY, ONE, TWO.
REQ-014 fifo_rd_en_o SHALL be combinational: high when fifo_empty_i=0, reset is deasserted, and (state!=TWO or (state==TWO and m_axis_tready_i=1 is ignored)), i.e. high only in EMPTY or ONE.
REQ-015 A word popped in EMPTY SHALL load main; the state becomes ONE; tvalid rises the next cycle (latency 1 clock from the head becoming valid).
REQ-016 In ONE with a pop and tready=1, main SHALL be replaced by the popped word and the state stays ONE, giving 1 word/clock sustained throughput.
REQ-017 In ONE with a pop and tready=0, the popped word SHALL go to skid and the state becomes TWO.
REQ-018 In ONE with no pop and tready=1, the state SHALL become EMPTY.
REQ-019 In TWO with tready=1, skid SHALL move to main and the state becomes ONE; with tready=0, the state stays TWO.
REQ-020 While tvalid=1 and tready=0, tdata and tlast SHALL remain stable.
REQ-021 m_axis_tvalid_o SHALL be 1 exactly in states ONE and TWO, and driven from a register.
REQ-022 Word order and tlast bits SHALL be preserved exactly; no word is dropped or duplicated.
REQ-023 pkt_cnt_o SHALL increment by 1 on each cycle with tvalid & tready & tlast, wrapping modulo 2^CNT_WIDTH.

Reset
REQ-024 While s_rst_n_i=0: state=EMPTY, m_axis_tvalid_o=0, m_axis_tdata_o=0, m_axis_tlast_o=0, fifo_rd_en_o=0, pkt_cnt_o=0.
REQ-025 Reset mid-packet SHALL discard buffered words with no partial handshake; the first transfer after reset is the FIFO head at that time.

Configuration
REQ-026 Macro PKT_CNT_EN: when defined, the packet counter of REQ-023 is built; when undefined, no counter logic exists and pkt_cnt_o is tied to 0.

Structure
REQ-027 Package axis_fifo_reader_pkg SHALL hold the occupancy-state enum typedef (EMPTY, ONE, TWO) and the TLAST_BIT position constant.
REQ-028 The two-entry buffer SHALL be a sub-module axis_skid_buf (data+tlast payload, valid/ready both sides), with FIFO glue and the counter kept in axis_fifo_reader.

Verification
REQ-029 FIFO holds 0x11,0x22,0x33(tlast), tready=1 -> three consecutive tvalid beats 0x11,0x22,0x33 with tlast on the third only; pkt_cnt_o=1.
REQ-030 Stream of 8 words, tready low on beats 3-5 -> tdata is held stable while stalled, state reaches TWO, fifo_rd_en_o=0 in TWO, and all 8 words arrive in order.
REQ-031 fifo_empty_i toggles every cycle with tready=1 -> no duplicate or lost word, and tvalid gaps match the empty cycles.
REQ-032 Reset asserted while state TWO with 0xAA,0xBB buffered -> next cycle tvalid=0 and pkt_cnt_o=0, and 0xAA/0xBB never appear after reset.
REQ-033 With CNT_WIDTH=4, send 17 single-word packets -> pkt_cnt_o wraps to 1. Without PKT_CNT_EN, pkt_cnt_o stays 0.
REQ-034 Random tready and empty patterns over 10000 words -> a scoreboard matches data and tlast exactly, and a protocol checker sees no tvalid drop without a handshake.
